// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing the single-port data memory between
//            two requesters; one access at a time, registered strobes.
//            Optional macro MEM_ARB_LOCK_EN adds P0Lock/P1Lock atomic runs.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              P0Req,
  input  logic              P0Write,
  input  logic [ADDR_W-1:0] P0Addr,
  input  logic [DATA_W-1:0] P0WData,
  output logic              P0Gnt,
  output logic              P0RValid,
  output logic [DATA_W-1:0] P0RData,
  input  logic              P1Req,
  input  logic              P1Write,
  input  logic [ADDR_W-1:0] P1Addr,
  input  logic [DATA_W-1:0] P1WData,
  output logic              P1Gnt,
  output logic              P1RValid,
  output logic [DATA_W-1:0] P1RData,
`ifdef MEM_ARB_LOCK_EN
  input  logic              P0Lock,
  input  logic              P1Lock,
`endif
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemReadEn,
  output logic              MemWriteEn,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic                sel_q;
  logic                lock_q;
  logic                wr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          gnt_q;
  logic [1:0]          rvalid_q;
  logic                re_q;
  logic                we_q;
  logic                busy_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic                w_any;
  logic                w_win;
  logic                w_win_wr;
  logic                w_win_lock;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic                w_p0_lock;
  logic                w_p1_lock;

`ifdef MEM_ARB_LOCK_EN
  assign w_p0_lock = P0Lock;
  assign w_p1_lock = P1Lock;
`else
  assign w_p0_lock = 1'b0;
  assign w_p1_lock = 1'b0;
`endif

  assign w_any = P0Req | P1Req;

  // sel_q doubles as the last-granted pointer; a held lock overrides alternation.
  always_comb begin
    w_win = 1'b0;
    if (lock_q && (sel_q ? P1Req : P0Req)) begin
      w_win = sel_q;
    end else if (P0Req && P1Req) begin
      w_win = ~sel_q;
    end else begin
      w_win = P1Req;
    end
  end

  assign w_win_wr    = w_win ? P1Write   : P0Write;
  assign w_win_addr  = w_win ? P1Addr    : P0Addr;
  assign w_win_wdata = w_win ? P1WData   : P0WData;
  assign w_win_lock  = w_win ? w_p1_lock : w_p0_lock;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b1;
      lock_q   <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_any) begin
            sel_q        <= w_win;
            lock_q       <= w_win_lock;
            wr_q         <= w_win_wr;
            addr_q       <= w_win_addr;
            wdata_q      <= w_win_wdata;
            gnt_q[w_win] <= 1'b1;
            we_q         <= w_win_wr;
            re_q         <= ~w_win_wr;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (wr_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= CNT_W'(READ_LAT);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (sel_q) begin
              rdata1_q <= MemRData;
            end else begin
              rdata0_q <= MemRData;
            end
            rvalid_q[sel_q] <= 1'b1;
            state_q         <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign P0Gnt      = gnt_q[0];
  assign P1Gnt      = gnt_q[1];
  assign P0RValid   = rvalid_q[0];
  assign P1RValid   = rvalid_q[1];
  assign P0RData    = rdata0_q;
  assign P1RData    = rdata1_q;
  assign MemAddr    = addr_q;
  assign MemWData   = wdata_q;
  assign MemReadEn  = re_q;
  assign MemWriteEn = we_q;
  assign Busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Scoreboard bench for mem_arbiter: instance A (READ_LAT=1) with a queue of
// expected grants/read returns, instance B (READ_LAT=3) for latency timing.
module tb_mem_arbiter;

  localparam int RL_A = 1;
  localparam int RL_B = 3;

  typedef struct packed {
    logic        p;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct packed {
    logic        p;
    logic [31:0] data;
    logic [31:0] due;
  } rv_t;

  logic Clock;
  logic nReset;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Instance A stimulus and observation
  logic        req   [2];
  logic        wr    [2];
  logic [15:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  a_gnt;
  logic [1:0]  a_rv;
  logic [31:0] a_rdata0;
  logic [31:0] a_rdata1;
  logic [15:0] a_maddr;
  logic        a_re;
  logic        a_we;
  logic [31:0] a_mwdata;
  logic [31:0] a_mrdata;
  logic        a_busy;
`ifdef MEM_ARB_LOCK_EN
  logic        lock  [2];
`endif

  // Instance B stimulus and observation
  logic        b_req;
  logic        b_wr;
  logic [15:0] b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_gnt;
  logic [1:0]  b_rv;
  logic [31:0] b_rdata0;
  logic [31:0] b_rdata1;
  logic [15:0] b_maddr;
  logic        b_re;
  logic        b_we;
  logic [31:0] b_mwdata;
  logic [31:0] b_mrdata;
  logic        b_busy;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(RL_A)) u_dut_a (
    .Clock      (Clock),
    .nReset     (nReset),
    .P0Req      (req[0]),
    .P0Write    (wr[0]),
    .P0Addr     (addr[0]),
    .P0WData    (wdata[0]),
    .P0Gnt      (a_gnt[0]),
    .P0RValid   (a_rv[0]),
    .P0RData    (a_rdata0),
    .P1Req      (req[1]),
    .P1Write    (wr[1]),
    .P1Addr     (addr[1]),
    .P1WData    (wdata[1]),
    .P1Gnt      (a_gnt[1]),
    .P1RValid   (a_rv[1]),
    .P1RData    (a_rdata1),
`ifdef MEM_ARB_LOCK_EN
    .P0Lock     (lock[0]),
    .P1Lock     (lock[1]),
`endif
    .MemAddr    (a_maddr),
    .MemReadEn  (a_re),
    .MemWriteEn (a_we),
    .MemWData   (a_mwdata),
    .MemRData   (a_mrdata),
    .Busy       (a_busy)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(RL_B)) u_dut_b (
    .Clock      (Clock),
    .nReset     (nReset),
    .P0Req      (b_req),
    .P0Write    (b_wr),
    .P0Addr     (b_addr),
    .P0WData    (b_wdata),
    .P0Gnt      (b_gnt[0]),
    .P0RValid   (b_rv[0]),
    .P0RData    (b_rdata0),
    .P1Req      (1'b0),
    .P1Write    (1'b0),
    .P1Addr     (16'h0000),
    .P1WData    (32'h0000_0000),
    .P1Gnt      (b_gnt[1]),
    .P1RValid   (b_rv[1]),
    .P1RData    (b_rdata1),
`ifdef MEM_ARB_LOCK_EN
    .P0Lock     (1'b0),
    .P1Lock     (1'b0),
`endif
    .MemAddr    (b_maddr),
    .MemReadEn  (b_re),
    .MemWriteEn (b_we),
    .MemWData   (b_mwdata),
    .MemRData   (b_mrdata),
    .Busy       (b_busy)
  );

  // Memory models: read data appears READ_LAT edges after the strobe edge;
  // non-read cycles push a poison word so early/late capture is visible.
  logic [31:0] mem_a  [256];
  logic [31:0] pipe_a [RL_A];
  logic [31:0] mem_b  [256];
  logic [31:0] pipe_b [RL_B];

  always @(posedge Clock) begin
    if (a_we) mem_a[a_maddr[7:0]] <= a_mwdata;
    pipe_a[0] <= a_re ? mem_a[a_maddr[7:0]] : 32'hDEAD_BEEF;
  end
  assign a_mrdata = pipe_a[RL_A-1];

  always @(posedge Clock) begin
    if (b_we) mem_b[b_maddr[7:0]] <= b_mwdata;
    pipe_b[0] <= b_re ? mem_b[b_maddr[7:0]] : 32'hDEAD_BEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mrdata = pipe_b[RL_B-1];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q [$];
  rv_t  rv_q  [$];
  logic [31:0] shadow [256];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, expv, $time);
    end
  endtask

  task automatic push(input int p, input bit w, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    e.p     = (p != 0);
    e.wr    = w;
    e.addr  = a;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  // Present a request and hold it until the matching grant is seen.
  task automatic access(input int p, input bit w, input logic [15:0] a, input logic [31:0] d,
                        input bit keep);
    int c;
    req[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d;
    for (c = 0; c < 60; c++) begin
      @(negedge Clock);
      if (a_gnt[p]) break;
    end
    if (c == 60) check("gnt_timeout", {1'b0, a_gnt[p]}, 2'b01);
    if (!keep) req[p] = 1'b0;
  endtask

  task automatic drain();
    int c;
    for (c = 0; c < 60; c++) begin
      @(negedge Clock);
      if (exp_q.size() == 0 && rv_q.size() == 0 && !a_busy) break;
    end
    check("drain_busy", a_busy, 0);
    check("drain_pending", exp_q.size() + rv_q.size(), 0);
  endtask

  // Scoreboard monitor for instance A.
  initial begin : mon_a
    exp_t e;
    rv_t  r;
    forever begin
      @(negedge Clock);
      cyc++;
      if (nReset) begin
        if (a_gnt != 2'b00 || a_re || a_we) begin
          if (exp_q.size() == 0) begin
            check("unexpected_gnt", {a_gnt, a_re, a_we}, 0);
          end else begin
            e = exp_q.pop_front();
            check("gnt_sel", a_gnt, e.p ? 2'b10 : 2'b01);
            check("mem_we", a_we, e.wr);
            check("mem_re", a_re, !e.wr);
            check("mem_addr", a_maddr, e.addr);
            check("busy_issue", a_busy, 1);
            if (e.wr) begin
              check("mem_wdata", a_mwdata, e.wdata);
              shadow[e.addr[7:0]] = e.wdata;
            end else begin
              r.p    = e.p;
              r.data = shadow[e.addr[7:0]];
              r.due  = cyc + RL_A + 1;
              rv_q.push_back(r);
            end
          end
        end
        if (a_rv != 2'b00) begin
          if (rv_q.size() == 0) begin
            check("unexpected_rvalid", a_rv, 0);
          end else begin
            r = rv_q.pop_front();
            check("rvalid_sel", a_rv, r.p ? 2'b10 : 2'b01);
            check("rdata", r.p ? a_rdata1 : a_rdata0, r.data);
            check("rvalid_latency", cyc, r.due);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c;
    int lat;
    int re_cnt;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
`ifdef MEM_ARB_LOCK_EN
      lock[i] = 1'b0;
`endif
    end
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    nReset = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_ctrl", {a_gnt, a_rv, a_re, a_we, a_busy}, 0);
    check("rst_maddr", a_maddr, 0);
    check("rst_rdata", {a_rdata0, a_rdata1}, 0);
    nReset = 1'b1;

    // Contention from reset: P0 wins the first tie, then strict alternation.
    push(0, 1'b1, 16'h0020, 32'h0BAD_0020);
    push(1, 1'b1, 16'h0021, 32'h0BAD_0021);
    push(0, 1'b0, 16'h0021, 32'h0);
    push(1, 1'b0, 16'h0020, 32'h0);
    fork
      begin
        access(0, 1'b1, 16'h0020, 32'h0BAD_0020, 1'b1);
        access(0, 1'b0, 16'h0021, 32'h0, 1'b0);
      end
      begin
        access(1, 1'b1, 16'h0021, 32'h0BAD_0021, 1'b1);
        access(1, 1'b0, 16'h0020, 32'h0, 1'b0);
      end
    join
    drain();

    // Single write, Busy drops the cycle after the grant.
    push(0, 1'b1, 16'h0010, 32'h1234_5678);
    access(0, 1'b1, 16'h0010, 32'h1234_5678, 1'b0);
    @(negedge Clock);
    check("busy_after_write", a_busy, 0);

    // P1 reads it back; P0's read register must be untouched.
    push(1, 1'b0, 16'h0010, 32'h0);
    access(1, 1'b0, 16'h0010, 32'h0, 1'b0);
    drain();
    check("p1_rdata_value", a_rdata1, 32'h1234_5678);
    check("p0_rdata_hold", a_rdata0, 32'h0BAD_0021);

    // Same requester back-to-back with no competitor.
    push(0, 1'b1, 16'h0030, 32'hCAFE_0030);
    push(0, 1'b0, 16'h0030, 32'h0);
    access(0, 1'b1, 16'h0030, 32'hCAFE_0030, 1'b1);
    access(0, 1'b0, 16'h0030, 32'h0, 1'b0);
    drain();

    // Reset during WAIT: outputs clear at once, the read is abandoned.
    push(0, 1'b0, 16'h0021, 32'h0);
    access(0, 1'b0, 16'h0021, 32'h0, 1'b0);
    @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    check("midrst_ctrl", {a_gnt, a_rv, a_re, a_we, a_busy}, 0);
    check("midrst_maddr", a_maddr, 0);
    check("midrst_mwdata", a_mwdata, 0);
    check("midrst_rdata0", a_rdata0, 0);
    check("midrst_rdata1", a_rdata1, 0);
    rv_q.delete();
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    repeat (3) @(negedge Clock);
    check("midrst_no_rvalid", a_rv, 0);
    push(0, 1'b1, 16'h0050, 32'h5050_0000);
    push(1, 1'b1, 16'h0051, 32'h5151_0000);
    fork
      access(0, 1'b1, 16'h0050, 32'h5050_0000, 1'b0);
      access(1, 1'b1, 16'h0051, 32'h5151_0000, 1'b0);
    join
    drain();

`ifdef MEM_ARB_LOCK_EN
    // Pointer to P0 first, then P1 locks and wins twice before P0.
    push(0, 1'b1, 16'h0060, 32'h6060_0000);
    access(0, 1'b1, 16'h0060, 32'h6060_0000, 1'b0);
    drain();
    push(1, 1'b1, 16'h0061, 32'h6161_0001);
    push(1, 1'b1, 16'h0062, 32'h6161_0002);
    push(0, 1'b1, 16'h0063, 32'h6363_0000);
    fork
      begin
        lock[1] = 1'b1;
        access(1, 1'b1, 16'h0061, 32'h6161_0001, 1'b1);
        lock[1] = 1'b0;
        access(1, 1'b1, 16'h0062, 32'h6161_0002, 1'b0);
      end
      access(0, 1'b1, 16'h0063, 32'h6363_0000, 1'b0);
    join
    drain();
`endif

    // Instance B: write then read with READ_LAT=3.
    b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0005; b_wdata = 32'hB0B0_0005;
    for (c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (b_gnt[0]) break;
    end
    check("b_wr_gnt", {b_gnt, b_we, b_re}, 4'b0110);
    b_req = 1'b0;
    @(negedge Clock);
    check("b_busy_after_write", b_busy, 0);
    b_req = 1'b1; b_wr = 1'b0;
    for (c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (b_gnt[0]) break;
    end
    check("b_rd_gnt", {b_gnt, b_re}, 3'b011);
    b_req = 1'b0;
    re_cnt = b_re ? 1 : 0;
    lat = 0;
    for (c = 0; c < 40; c++) begin
      @(negedge Clock);
      lat++;
      if (b_re) re_cnt++;
      if (b_rv != 2'b00) break;
    end
    check("b_rvalid_latency", lat, RL_B + 1);
    check("b_rvalid_sel", b_rv, 2'b01);
    check("b_rdata", b_rdata0, 32'hB0B0_0005);
    check("b_memre_cycles", re_cnt, 1);
    check("b_rdata1_idle", b_rdata1, 0);
    @(negedge Clock);
    check("b_busy_after_read", b_busy, 0);

    check("final_queues", exp_q.size() + rv_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
